// File: rtl/funrv_pkg.sv
// funrv_pkg: shared fetch state encoding and RV32I constants
package funrv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch FSM with held instruction register
// Optional illegal-instruction trap enabled by defining FETCH_TRAP_EN.
module fetch_sequencer
  import funrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_inst_illegal,
  output logic            o_trap
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic req_q, req_d, valid_q, valid_d, trap_q, trap_d;
  logic [XLEN-1:0] redir_pc;
  assign redir_pc = i_redirect_pc & ~32'h3;
`ifndef FETCH_TRAP_EN
  logic unused_illegal;
  assign unused_illegal = i_inst_illegal;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_d = req_q;
    addr_d = addr_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d = valid_q;
    trap_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = i_redirect ? redir_pc : pc_q;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (i_redirect) begin
          pc_d = redir_pc;
          req_d = 1'b0;
          addr_d = redir_pc;
          state_d = i_imem_gnt ? S_DRAIN : S_IDLE;
        end else if (i_imem_gnt) begin
          req_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_redirect) begin
          pc_d = redir_pc;
          state_d = i_imem_rvalid ? S_REQ : S_DRAIN;
        end else if (i_imem_rvalid) begin
          inst_d = i_imem_rdata;
          inst_pc_d = pc_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          pc_d = redir_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
`ifdef FETCH_TRAP_EN
        end else if (i_inst_illegal) begin
          trap_d = 1'b1;
          pc_d = TRAP_VEC;
          valid_d = 1'b0;
          state_d = S_REQ;
`endif
        end else if (i_inst_ready) begin
          pc_d = pc_q + PC_INC;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        pc_d = i_redirect ? redir_pc : pc_q;
        state_d = i_imem_rvalid ? S_REQ : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
    // every entry into S_REQ issues the request for the freshly chosen PC
    if (state_d == S_REQ && state_q != S_REQ) begin
      req_d = 1'b1;
      addr_d = pc_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      req_q <= 1'b0;
      addr_q <= RESET_PC;
      inst_q <= NOP;
      inst_pc_q <= RESET_PC;
      valid_q <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_q <= req_d;
      addr_q <= addr_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q <= valid_d;
      trap_q <= trap_d;
    end
  end
  assign o_imem_req = req_q;
  assign o_imem_addr = addr_q;
  assign o_inst = inst_q;
  assign o_inst_pc = inst_pc_q;
  assign o_inst_valid = valid_q;
  assign o_trap = trap_q;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch controller for the RV32I core. It owns the PC and issues single-outstanding requests on the instruction-memory handshake. It captures each returned word into a held instruction register that drives inst_decoder's i_inst, and presents the instruction to execute with a valid/ready handshake. Execute-stage redirects (jumps, taken branches) override sequential PC+4.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
TRAP_VEC, 32'h0000_0010, target PC on illegal-instruction trap (used only with FETCH_TRAP_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
o_imem_req  out  1  fetch request
o_imem_addr  out  32  fetch address, word aligned
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  read data valid
i_imem_rdata  in  32  read data
o_inst  out  32  held instruction, to decoder i_inst
o_inst_pc  out  32  PC of o_inst
o_inst_valid  out  1  o_inst valid for execute
i_inst_ready  in  1  execute consumes o_inst
i_redirect  in  1  redirect request from execute
i_redirect_pc  in  32  redirect target
i_inst_illegal  in  1  decoder illegal flag for o_inst
o_trap  out  1  one-cycle illegal-instruction trap pulse

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high. Reset overrides everything, including mid-transaction.
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_inst=32'h0000_0013 (NOP), o_inst_pc=RESET_PC, o_inst_valid=0, o_trap=0, state=S_IDLE.
- Memory protocol: one outstanding request; o_imem_addr is stable while o_imem_req=1 and i_imem_gnt=0. i_imem_rvalid arrives at least 1 cycle after gnt. Unexpected rvalid in S_IDLE, S_REQ or S_HOLD is ignored.
- FSM states:
  - S_IDLE: transitions to S_REQ unconditionally; first req is asserted 1 cycle after reset release.
  - S_REQ: req=1, addr=pc. On gnt, go to S_WAIT.
  - S_WAIT: on rvalid, o_inst<=rdata, o_inst_pc<=pc, o_inst_valid<=1, go to S_HOLD.
  - S_HOLD: valid=1. On ready: pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), valid<=0, go to S_REQ.
  - S_DRAIN: req=0. Wait for rvalid, discard the data, go to S_REQ.
- Minimum turnaround: gnt at cycle t, rvalid at t+1, valid at t+2. With ready at t+2, the next req is at t+3.
- Redirect (i_redirect=1) has priority over sequential PC+4. Target pc<=i_redirect_pc with bits[1:0] forced to 0. Per state:
  - S_REQ without gnt: request abandoned, req=0 for 1 cycle, new address next cycle.
  - S_REQ with gnt: go to S_DRAIN.
  - S_WAIT without rvalid: go to S_DRAIN.
  - S_WAIT with rvalid: data discarded, go to S_REQ.
  - S_HOLD: valid<=0, go to S_REQ. If ready is high in the same cycle, the handshake still counts as completed; the redirect still wins for the next PC.
  - S_IDLE and S_DRAIN: pc updated, state transition unchanged.
- o_inst keeps its last value while invalid; the decoder output is meaningful only when o_inst_valid=1.

Optional Feature:
FETCH_TRAP_EN
- Defined: in S_HOLD, o_inst_valid=1 with i_inst_illegal=1 causes the following, with no wait for ready:
  - o_trap pulses 1 for 1 cycle.
  - valid<=0 and pc<=TRAP_VEC, go to S_REQ.
  - i_redirect in the same cycle has priority over the trap; no trap pulse is raised.
- Undefined: o_trap tied 0 and i_inst_illegal ignored; illegal instructions are handed to execute like any other.

Decomposition:
- Shared package funrv_pkg: fetch state enum (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN), XLEN=32, NOP encoding 32'h0000_0013, PC increment 4.
- No sub-module: the FSM and PC register form one block. inst_decoder is instantiated by the parent, fed from o_inst, and its o_inst_illegal is wired back to i_inst_illegal.

Test Plan:
- Reset then zero-wait memory (gnt with req, rvalid 1 cycle later, ready tied 1) -> addrs 0x0,0x4,0x8 issued; valid rises 2 cycles after each gnt; o_inst_pc matches.
- gnt held low 3 cycles -> addr stays 0x0 and req stays 1; no valid until gnt, then rvalid.
- Redirect to 0x103 in S_WAIT; stale rvalid rdata=0xDEADBEEF arrives 2 cycles later -> data dropped; next req addr=0x100; 0xDEADBEEF never presented.
- S_HOLD with ready=1 and redirect=1 to 0x40 in the same cycle -> single handshake; next addr 0x40, not pc+4.
- PC=0xFFFF_FFFC, ready -> next addr 0x0000_0000.
- FETCH_TRAP_EN: rdata 0xFFFFFFFF with decoder illegal -> o_trap pulses 1 cycle; next addr=0x10; valid dropped without ready. Without the macro -> o_trap stays 0 and the instruction is held until ready.
